// File: rtl/ksz_init_pkg.sv
// Shared types and constants for the KSZ8851 init sequencer.
// Holds the step op encodings, the ROM entry layout, the FSM state type and
// the MAC register offsets used by the default step table.
package ksz_init_pkg;

  localparam int unsigned DW = 16;  // register data width
  localparam int unsigned AW = 8;   // register offset width
  localparam int unsigned SW = 6;   // step index width (up to 64 steps)

  typedef enum logic [1:0] {
    OP_WRITE  = 2'd0,
    OP_VERIFY = 2'd1,
    OP_RMW    = 2'd2,
    OP_DELAY  = 2'd3
  } op_e;

  // One ROM entry: VERIFY passes on (rdata & b) == a, RMW writes (rdata & ~b) | a,
  // DELAY waits a clocks.
  typedef struct packed {
    op_e           op;
    logic [AW-1:0] offset;
    logic [DW-1:0] a;
    logic [DW-1:0] b;
  } step_t;

  typedef enum logic [3:0] {
    S_WARM     = 4'd0,
    S_FETCH    = 4'd1,
    S_ISSUE    = 4'd2,
    S_WAIT_RSP = 4'd3,
    S_CHECK    = 4'd4,
    S_WB_ISSUE = 4'd5,
    S_WB_WAIT  = 4'd6,
    S_DELAY    = 4'd7,
    S_NEXT     = 4'd8,
    S_DONE     = 4'd9,
    S_ERROR    = 4'd10
  } state_e;

  localparam logic [AW-1:0] REG_CIDER  = 8'hC0;
  localparam logic [AW-1:0] REG_MARL   = 8'h10;
  localparam logic [AW-1:0] REG_MARM   = 8'h12;
  localparam logic [AW-1:0] REG_MARH   = 8'h14;
  localparam logic [AW-1:0] REG_TXFDPR = 8'h84;
  localparam logic [AW-1:0] REG_TXCR   = 8'h70;
  localparam logic [AW-1:0] REG_RXFDPR = 8'h86;
  localparam logic [AW-1:0] REG_RXFCTR = 8'h9C;
  localparam logic [AW-1:0] REG_RXCR1  = 8'h74;
  localparam logic [AW-1:0] REG_RXCR2  = 8'h76;
  localparam logic [AW-1:0] REG_RXQCR  = 8'h82;
  localparam logic [AW-1:0] REG_P1CR   = 8'hF6;
  localparam logic [AW-1:0] REG_ISR    = 8'h92;
  localparam logic [AW-1:0] REG_IER    = 8'h90;

  function automatic step_t mk_step(input op_e op, input logic [AW-1:0] off,
                                    input logic [DW-1:0] a, input logic [DW-1:0] b);
    step_t s;
    s.op     = op;
    s.offset = off;
    s.a      = a;
    s.b      = b;
    return s;
  endfunction

endpackage

// File: rtl/ksz_init_if.sv
// Command/response port between the init sequencer and the bus controller.
//   cmd_*  : valid/ready command (wr, offset, length, wdata), master drives
//   rsp_*  : one-cycle completion pulse with read data, slave drives
interface ksz_init_if;
  import ksz_init_pkg::*;

  logic          cmd_valid;
  logic          cmd_ready;
  logic          cmd_wr;
  logic [AW-1:0] cmd_offset;
  logic          cmd_length;
  logic [DW-1:0] cmd_wdata;
  logic          rsp_valid;
  logic [DW-1:0] rsp_rdata;

  modport master (
    output cmd_valid, cmd_wr, cmd_offset, cmd_length, cmd_wdata,
    input  cmd_ready, rsp_valid, rsp_rdata
  );

  modport slave (
    input  cmd_valid, cmd_wr, cmd_offset, cmd_length, cmd_wdata,
    output cmd_ready, rsp_valid, rsp_rdata
  );

endinterface

// File: rtl/ksz_init_rom.sv
// Combinational step table for the KSZ8851 bring-up sequence.
//   i_step    : step index
//   o_entry_c : ROM entry for i_step (combinational)
// Indices past the table return a short settle DELAY.
module ksz_init_rom
  import ksz_init_pkg::*;
(
  input  logic [SW-1:0] i_step,
  output step_t         o_entry_c
);

  always_comb begin
    o_entry_c = mk_step(OP_DELAY, '0, 16'h0008, '0);
    case (i_step)
      6'd0:  o_entry_c = mk_step(OP_VERIFY, REG_CIDER,  16'h8870, 16'hFFF0);
      6'd1:  o_entry_c = mk_step(OP_WRITE,  REG_MARL,   16'h89AB, 16'h0000);
      6'd2:  o_entry_c = mk_step(OP_WRITE,  REG_MARM,   16'h4567, 16'h0000);
      6'd3:  o_entry_c = mk_step(OP_WRITE,  REG_MARH,   16'h0123, 16'h0000);
      6'd4:  o_entry_c = mk_step(OP_WRITE,  REG_TXFDPR, 16'h4000, 16'h0000);
      6'd5:  o_entry_c = mk_step(OP_WRITE,  REG_TXCR,   16'h01EE, 16'h0000);
      6'd6:  o_entry_c = mk_step(OP_WRITE,  REG_RXFDPR, 16'h4000, 16'h0000);
      6'd7:  o_entry_c = mk_step(OP_WRITE,  REG_RXFCTR, 16'h0001, 16'h0000);
      6'd8:  o_entry_c = mk_step(OP_WRITE,  REG_RXCR1,  16'h74F2, 16'h0000);
      6'd9:  o_entry_c = mk_step(OP_WRITE,  REG_RXCR2,  16'h0016, 16'h0000);
      6'd10: o_entry_c = mk_step(OP_WRITE,  REG_RXQCR,  16'h0030, 16'h0000);
      6'd11: o_entry_c = mk_step(OP_RMW,    REG_P1CR,   16'h2000, 16'h0020);
      6'd12: o_entry_c = mk_step(OP_WRITE,  REG_ISR,    16'hFFFF, 16'h0000);
      6'd13: o_entry_c = mk_step(OP_WRITE,  REG_IER,    16'h6000, 16'h0000);
      6'd14: o_entry_c = mk_step(OP_RMW,    REG_TXCR,   16'h0001, 16'h0000);
      6'd15: o_entry_c = mk_step(OP_RMW,    REG_RXCR1,  16'h0001, 16'h0000);
      default: ;
    endcase
  end

endmodule

// File: rtl/ksz_init_sequencer.sv
// Table-driven KSZ8851 register init sequencer.
//   i_clk40m, i_reset (async, active low), i_restart (re-run from step 0)
//   bus          : command/response master port
//   o_init_done  : sequence complete (sticky)
//   o_init_error : retries exhausted (sticky), o_err_step holds the failing step
//   o_cur_step   : step currently executing
module ksz_init_sequencer
  import ksz_init_pkg::*;
#(
  parameter int unsigned WARM_CYCLES    = 2097152,
  parameter int unsigned NUM_STEPS      = 20,
  parameter int unsigned TIMEOUT_CYCLES = 1024,
  parameter int unsigned MAX_RETRY      = 3
) (
  input  logic          i_clk40m,
  input  logic          i_reset,
  input  logic          i_restart,
  ksz_init_if.master    bus,
  output logic          o_init_done,
  output logic          o_init_error,
  output logic [SW-1:0] o_err_step,
  output logic [SW-1:0] o_cur_step
);

  localparam int unsigned WW  = (WARM_CYCLES > 1) ? $clog2(WARM_CYCLES) : 1;
  localparam int unsigned TOW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  // Shared timeout/delay counter must also cover a full DW-bit delay.
  localparam int unsigned TW  = (TOW > DW) ? TOW : DW;
  localparam int unsigned RW  = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

  state_e          r_state, w_next_state;
  logic [WW-1:0]   r_warm;
  logic [TW-1:0]   r_cnt;
  logic [RW-1:0]   r_retry;
  logic [SW-1:0]   r_step;
  step_t           r_entry, w_rom;
  logic [DW-1:0]   r_rdata;
  logic            r_cmd_valid, r_cmd_wr;
  logic [AW-1:0]   r_cmd_offset;
  logic [DW-1:0]   r_cmd_wdata;
  logic            r_init_done, r_init_error;
  logic [SW-1:0]   r_err_step;
  logic            w_fail, w_timeout, w_restart, w_last, w_verify_ok, w_cnt_run;
  logic [DW-1:0]   w_rmw_data;

  ksz_init_rom u_rom (
    .i_step    (r_step),
    .o_entry_c (w_rom)
  );

  assign w_restart   = i_restart && (r_state != S_WARM);
  assign w_timeout   = (r_cnt == TW'(TIMEOUT_CYCLES - 1));
  assign w_last      = (r_step == SW'(NUM_STEPS - 1));
  assign w_verify_ok = ((r_rdata & r_entry.b) == r_entry.a);
  assign w_rmw_data  = (bus.rsp_rdata & ~r_entry.b) | r_entry.a;
  assign w_cnt_run   = (r_state == S_ISSUE) || (r_state == S_WAIT_RSP) ||
                       (r_state == S_WB_ISSUE) || (r_state == S_WB_WAIT) ||
                       (r_state == S_DELAY);

  // State register
  always_ff @(posedge i_clk40m or negedge i_reset) begin
    if (!i_reset) r_state <= S_WARM;
    else          r_state <= w_next_state;
  end

  // Next-state logic; a failure either retries the whole step or ends in ERROR
  always_comb begin
    w_next_state = r_state;
    w_fail       = 1'b0;
    case (r_state)
      S_WARM:     if (r_warm == WW'(WARM_CYCLES - 1)) w_next_state = S_FETCH;
      S_FETCH:    w_next_state = (w_rom.op == OP_DELAY) ? S_DELAY : S_ISSUE;
      S_ISSUE:    if (bus.cmd_ready) w_next_state = S_WAIT_RSP;
                  else if (w_timeout) w_fail = 1'b1;
      S_WAIT_RSP: if (bus.rsp_valid) begin
                    case (r_entry.op)
                      OP_VERIFY: w_next_state = S_CHECK;
                      OP_RMW:    w_next_state = S_WB_ISSUE;
                      default:   w_next_state = S_NEXT;
                    endcase
                  end else if (w_timeout) w_fail = 1'b1;
      S_CHECK:    if (w_verify_ok) w_next_state = S_NEXT;
                  else w_fail = 1'b1;
      S_WB_ISSUE: if (bus.cmd_ready) w_next_state = S_WB_WAIT;
                  else if (w_timeout) w_fail = 1'b1;
      S_WB_WAIT:  if (bus.rsp_valid) w_next_state = S_NEXT;
                  else if (w_timeout) w_fail = 1'b1;
      S_DELAY:    if ((r_cnt + TW'(1)) >= TW'(r_entry.a)) w_next_state = S_NEXT;
      S_NEXT:     w_next_state = w_last ? S_DONE : S_FETCH;
      default:    ;
    endcase
    if (w_fail) w_next_state = (r_retry < RW'(MAX_RETRY)) ? S_FETCH : S_ERROR;
    if (w_restart) begin
      w_next_state = S_FETCH;
      w_fail       = 1'b0;
    end
  end

  // Counters, captured entry/read data and registered outputs
  always_ff @(posedge i_clk40m or negedge i_reset) begin
    if (!i_reset) begin
      r_warm       <= '0;
      r_cnt        <= '0;
      r_retry      <= '0;
      r_step       <= '0;
      r_entry      <= '0;
      r_rdata      <= '0;
      r_cmd_valid  <= 1'b0;
      r_cmd_wr     <= 1'b0;
      r_cmd_offset <= '0;
      r_cmd_wdata  <= '0;
      r_init_done  <= 1'b0;
      r_init_error <= 1'b0;
      r_err_step   <= '0;
    end else begin
      if (r_state == S_WARM) r_warm <= r_warm + WW'(1);

      // Clears on every state change so each wait phase gets a fresh budget
      if (w_next_state != r_state) r_cnt <= '0;
      else if (w_cnt_run)          r_cnt <= r_cnt + TW'(1);

      if (r_state == S_FETCH) r_entry <= w_rom;
      if (r_state == S_WAIT_RSP && bus.rsp_valid) r_rdata <= bus.rsp_rdata;

      if (w_restart) begin
        r_step  <= '0;
        r_retry <= '0;
      end else if (r_state == S_NEXT) begin
        r_retry <= '0;
        if (!w_last) r_step <= r_step + SW'(1);
      end else if (w_fail && (w_next_state == S_FETCH)) begin
        r_retry <= r_retry + RW'(1);
      end

      r_cmd_valid <= (w_next_state == S_ISSUE) || (w_next_state == S_WB_ISSUE);
      if (r_state == S_FETCH && w_next_state == S_ISSUE) begin
        r_cmd_wr     <= (w_rom.op == OP_WRITE);
        r_cmd_offset <= w_rom.offset;
        r_cmd_wdata  <= (w_rom.op == OP_WRITE) ? w_rom.a : '0;
      end else if (r_state == S_WAIT_RSP && w_next_state == S_WB_ISSUE) begin
        r_cmd_wr     <= 1'b1;
        r_cmd_wdata  <= w_rmw_data;
      end

      r_init_done  <= (w_next_state == S_DONE);
      r_init_error <= (w_next_state == S_ERROR);
      if (w_restart) r_err_step <= '0;
      else if (w_next_state == S_ERROR && r_state != S_ERROR) r_err_step <= r_step;
    end
  end

  assign bus.cmd_valid  = r_cmd_valid;
  assign bus.cmd_wr     = r_cmd_wr;
  assign bus.cmd_offset = r_cmd_offset;
  assign bus.cmd_length = 1'b1;
  assign bus.cmd_wdata  = r_cmd_wdata;
  assign o_init_done    = r_init_done;
  assign o_init_error   = r_init_error;
  assign o_err_step     = r_err_step;
  assign o_cur_step     = r_step;

endmodule

// File: tb/tb_ksz_init_sequencer.sv
// Scoreboard bench for ksz_init_sequencer: a responder model answers commands
// and compares each accepted command against the expected queue.
module tb_ksz_init_sequencer;
  import ksz_init_pkg::*;

  localparam int NSTEP = 20;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       restart;
  logic       init_done, init_error;
  logic [5:0] err_step, cur_step;

  ksz_init_if bus();

  ksz_init_sequencer #(
    .WARM_CYCLES(8), .NUM_STEPS(NSTEP), .TIMEOUT_CYCLES(1024), .MAX_RETRY(3)
  ) dut (
    .i_clk40m    (clk),
    .i_reset     (rst_n),
    .i_restart   (restart),
    .bus         (bus.master),
    .o_init_done (init_done),
    .o_init_error(init_error),
    .o_err_step  (err_step),
    .o_cur_step  (cur_step)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Expected step table and responder read values
  op_e         t_op  [NSTEP];
  logic [7:0]  t_off [NSTEP];
  logic [15:0] t_a   [NSTEP];
  logic [15:0] t_b   [NSTEP];
  logic [15:0] rd_cider, rd_p1cr, rd_txcr, rd_rxcr1;

  logic [24:0] sb[$];
  int          n_pushed;
  int          drop_idx = -1;
  int          t_rel = 0;

  // Written only by the responder
  int   hs_count = 0;
  int   cider_reads = 0;
  int   t_drop = 0;
  logic drop_pending = 1'b0;
  logic seen_marl = 1'b0, seen_p1cr = 1'b0, seen_txcr = 1'b0;

  function automatic logic [15:0] read_val(input logic [7:0] off);
    case (off)
      8'hC0:   return rd_cider;
      8'hF6:   return rd_p1cr;
      8'h70:   return rd_txcr;
      8'h74:   return rd_rxcr1;
      default: return 16'h0000;
    endcase
  endfunction

  task automatic set_step(input int i, input op_e op, input logic [7:0] off,
                          input logic [15:0] a, input logic [15:0] b);
    t_op[i] = op; t_off[i] = off; t_a[i] = a; t_b[i] = b;
  endtask

  task automatic push_steps(input int first, input int last);
    for (int i = first; i <= last; i++) begin
      case (t_op[i])
        OP_WRITE:  begin sb.push_back({1'b1, t_off[i], t_a[i]}); n_pushed++; end
        OP_VERIFY: begin sb.push_back({1'b0, t_off[i], 16'h0000}); n_pushed++; end
        OP_RMW: begin
          sb.push_back({1'b0, t_off[i], 16'h0000});
          sb.push_back({1'b1, t_off[i], (read_val(t_off[i]) & ~t_b[i]) | t_a[i]});
          n_pushed += 2;
        end
        default: ;
      endcase
    end
  endtask

  // Responder: ready one clock after valid, response two clocks after accept
  initial begin : responder
    logic [24:0] exp_c;
    logic [15:0] rd;
    logic        do_drop;
    int          t_det;
    bus.cmd_ready = 1'b0;
    bus.rsp_valid = 1'b0;
    bus.rsp_rdata = '0;
    forever begin
      @(negedge clk);
      if (rst_n !== 1'b1) begin
        hs_count = 0; cider_reads = 0; drop_pending = 1'b0;
        seen_marl = 1'b0; seen_p1cr = 1'b0; seen_txcr = 1'b0;
      end else if (bus.cmd_valid) begin
        t_det = cyc;
        if (hs_count == 0) check("warm_latency", 32'(cyc - t_rel), 32'd9);
        if (drop_pending) begin
          check("timeout_gap", 32'(cyc - t_drop), 32'd1026);
          drop_pending = 1'b0;
        end
        if (sb.size() == 0) check("sb_underflow", 32'(sb.size()), 32'd1);
        else begin
          exp_c = sb.pop_front();
          check("cmd_wr", 32'(bus.cmd_wr), 32'(exp_c[24]));
          check("cmd_offset", 32'(bus.cmd_offset), 32'(exp_c[23:16]));
          check("cmd_wdata", 32'(bus.cmd_wdata), 32'(exp_c[15:0]));
        end
        check("cmd_length", 32'(bus.cmd_length), 32'd1);
        if (bus.cmd_wr && bus.cmd_offset == 8'h10 && bus.cmd_wdata == 16'h89AB) seen_marl = 1'b1;
        if (bus.cmd_wr && bus.cmd_offset == 8'hF6 && bus.cmd_wdata == 16'h20DF) seen_p1cr = 1'b1;
        if (bus.cmd_wr && bus.cmd_offset == 8'h70 && bus.cmd_wdata == 16'h0001) seen_txcr = 1'b1;
        if (!bus.cmd_wr && bus.cmd_offset == 8'hC0) cider_reads++;
        rd      = bus.cmd_wr ? 16'h0000 : read_val(bus.cmd_offset);
        do_drop = (hs_count == drop_idx);
        hs_count++;
        bus.cmd_ready = 1'b1;
        @(negedge clk);
        bus.cmd_ready = 1'b0;
        if (do_drop) begin
          drop_pending = 1'b1;
          t_drop = t_det;
        end else begin
          @(negedge clk);
          bus.rsp_valid = 1'b1; bus.rsp_rdata = rd;
          @(negedge clk);
          bus.rsp_valid = 1'b0; bus.rsp_rdata = '0;
        end
      end
    end
  end

  task automatic do_reset();
    rst_n = 1'b0; restart = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_cmd_valid", 32'(bus.cmd_valid), 32'd0);
    check("rst_cmd_length", 32'(bus.cmd_length), 32'd1);
    check("rst_done", 32'(init_done), 32'd0);
    check("rst_error", 32'(init_error), 32'd0);
    check("rst_err_step", 32'(err_step), 32'd0);
    check("rst_cur_step", 32'(cur_step), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    t_rel = cyc;
  endtask

  task automatic setup(input logic [15:0] cider, input logic [15:0] p1cr,
                       input logic [15:0] txcr, input logic [15:0] rxcr1, input int drop);
    rd_cider = cider; rd_p1cr = p1cr; rd_txcr = txcr; rd_rxcr1 = rxcr1;
    drop_idx = drop;
    sb.delete();
    n_pushed = 0;
  endtask

  task automatic wait_outcome(input int max_cyc);
    for (int i = 0; i < max_cyc; i++) begin
      @(negedge clk);
      if (init_done || init_error) break;
    end
    check("outcome_seen", 32'(init_done | init_error), 32'd1);
  endtask

  task automatic check_done();
    check("done", 32'(init_done), 32'd1);
    check("no_error", 32'(init_error), 32'd0);
    check("sb_left", 32'(sb.size()), 32'd0);
    check("hs_count", 32'(hs_count), 32'(n_pushed));
    check("idle_valid", 32'(bus.cmd_valid), 32'd0);
  endtask

  initial begin : main
    int gap;
    rst_n = 1'b0; restart = 1'b0;
    set_step(0,  OP_VERIFY, 8'hC0, 16'h8870, 16'hFFF0);
    set_step(1,  OP_WRITE,  8'h10, 16'h89AB, 16'h0000);
    set_step(2,  OP_WRITE,  8'h12, 16'h4567, 16'h0000);
    set_step(3,  OP_WRITE,  8'h14, 16'h0123, 16'h0000);
    set_step(4,  OP_WRITE,  8'h84, 16'h4000, 16'h0000);
    set_step(5,  OP_WRITE,  8'h70, 16'h01EE, 16'h0000);
    set_step(6,  OP_WRITE,  8'h86, 16'h4000, 16'h0000);
    set_step(7,  OP_WRITE,  8'h9C, 16'h0001, 16'h0000);
    set_step(8,  OP_WRITE,  8'h74, 16'h74F2, 16'h0000);
    set_step(9,  OP_WRITE,  8'h76, 16'h0016, 16'h0000);
    set_step(10, OP_WRITE,  8'h82, 16'h0030, 16'h0000);
    set_step(11, OP_RMW,    8'hF6, 16'h2000, 16'h0020);
    set_step(12, OP_WRITE,  8'h92, 16'hFFFF, 16'h0000);
    set_step(13, OP_WRITE,  8'h90, 16'h6000, 16'h0000);
    set_step(14, OP_RMW,    8'h70, 16'h0001, 16'h0000);
    set_step(15, OP_RMW,    8'h74, 16'h0001, 16'h0000);
    for (int i = 16; i < NSTEP; i++) set_step(i, OP_DELAY, 8'h00, 16'h0008, 16'h0000);

    // 1: nominal run with non-trivial RMW read-back values
    setup(16'h8870, 16'h1234, 16'h0100, 16'h0F00, -1);
    push_steps(0, NSTEP - 1);
    do_reset();
    wait_outcome(3000);
    check_done();
    check("marl_write_seen", 32'(seen_marl), 32'd1);
    check("cur_step_last", 32'(cur_step), 32'd19);

    // 2: masked CIDER match; restart pulsed during warm-up must be ignored
    setup(16'h8872, 16'h0000, 16'h0000, 16'h0000, -1);
    push_steps(0, NSTEP - 1);
    do_reset();
    repeat (2) @(negedge clk);
    restart = 1'b1;
    @(negedge clk);
    restart = 1'b0;
    wait_outcome(3000);
    check_done();

    // 3: CIDER never matches -> 1 + 3 retries, then sticky error at step 0
    setup(16'h1234, 16'h0000, 16'h0000, 16'h0000, -1);
    for (int r = 0; r < 4; r++) push_steps(0, 0);
    do_reset();
    wait_outcome(3000);
    check("err_flag", 32'(init_error), 32'd1);
    check("err_no_done", 32'(init_done), 32'd0);
    check("err_step", 32'(err_step), 32'd0);
    repeat (100) @(negedge clk);
    check("err_valid_low", 32'(bus.cmd_valid), 32'd0);
    check("err_cider_reads", 32'(cider_reads), 32'd4);
    check("err_hs_count", 32'(hs_count), 32'(n_pushed));
    check("err_sticky", 32'(init_error), 32'd1);

    // 4: RMW write-back values
    setup(16'h8870, 16'h00FF, 16'h0000, 16'h0000, -1);
    push_steps(0, NSTEP - 1);
    do_reset();
    wait_outcome(3000);
    check_done();
    check("p1cr_wb_20df", 32'(seen_p1cr), 32'd1);
    check("txcr_wb_0001", 32'(seen_txcr), 32'd1);

    // 5: response withheld at step 5 -> timeout, same command reissued
    setup(16'h8870, 16'h0000, 16'h0000, 16'h0000, 5);
    push_steps(0, 5);
    push_steps(5, NSTEP - 1);
    do_reset();
    wait_outcome(5000);
    check_done();
    check("drop_reissued", 32'(drop_pending), 32'd0);

    // 6: restart while waiting on step 7; stale response must be ignored
    setup(16'h8870, 16'h0000, 16'h0000, 16'h0000, -1);
    push_steps(0, 7);
    do_reset();
    for (int i = 0; i < 500; i++) begin
      @(posedge clk); #2;
      if (hs_count >= 8) break;
    end
    check("rs_hs_reached", 32'(hs_count), 32'd8);
    @(negedge clk);
    check("rs_cur_step", 32'(cur_step), 32'd7);
    push_steps(0, NSTEP - 1);
    restart = 1'b1;
    gap = cyc;
    @(negedge clk);
    restart = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (bus.cmd_valid) break;
      @(negedge clk);
    end
    check("rs_latency", 32'(cyc - gap), 32'd2);
    check("rs_step0", 32'(cur_step), 32'd0);
    wait_outcome(3000);
    check_done();
    check("rs_err_step", 32'(err_step), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/ksz_init_sequencer.md
Name: ksz_init_sequencer

Overview:
Table-driven, parametrised register-initialisation sequencer for the KSZ8851 Ethernet MAC. It replaces hard-coded per-step init logic. After a power-up warm-up delay, it walks a step ROM and issues commands to the bus controller through a valid/ready command port. Supported step types are plain write, read-verify and read-modify-write, with per-transaction timeout, bounded retry and error reporting. A restart input re-runs the whole sequence without reset.

Parameters:
- WARM_CYCLES, 2097152: clocks to wait after reset before step 0 (0.0524 s at 40 MHz).
- NUM_STEPS, 20: number of ROM entries executed (1..64).
- TIMEOUT_CYCLES, 1024: maximum clocks waiting for cmd_ready or rsp_valid per transaction.
- MAX_RETRY, 3: retries per step after a verify mismatch or timeout before declaring error.
- DW, 16: register data width.
- AW, 8: register offset width.

Ports:
- clk40m, in, 1: system clock.
- reset, in, 1: asynchronous, active-low reset.
- restart, in, 1: single-cycle pulse; restarts the sequence from step 0, skipping warm-up.
- cmd_valid, out, 1: command request; held high until accepted.
- cmd_ready, in, 1: controller accepts a command when cmd_valid && cmd_ready.
- cmd_wr, out, 1: 1 = write, 0 = read.
- cmd_offset, out, AW: register offset.
- cmd_length, out, 1: always 1 (16-bit access).
- cmd_wdata, out, DW: write data; 0 for reads.
- rsp_valid, in, 1: one-cycle completion pulse, for reads and writes.
- rsp_rdata, in, DW: read data, valid only with rsp_valid.
- init_done, out, 1: sequence completed; sticky until reset or restart.
- init_error, out, 1: retries exhausted; sticky until reset or restart.
- err_step, out, 6: step index that failed.
- cur_step, out, 6: step currently executing.

Behaviour:
- Reset values: all outputs 0; cmd_length 1; FSM in WARM; warm counter, step, retry and timeout counters all 0.
- ROM entry fields: op[1:0] (0 WRITE, 1 VERIFY, 2 RMW, 3 DELAY), offset[AW-1:0], a[DW-1:0], b[DW-1:0].
  - WRITE: write a.
  - VERIFY: read; pass when (rdata & b) == a.
  - RMW: read, then write (rdata & ~b) | a.
  - DELAY: wait a clocks; no bus access.
- States: WARM -> FETCH -> ISSUE -> WAIT_RSP -> {CHECK | WB_ISSUE -> WB_WAIT} -> NEXT -> FETCH ... -> DONE; any failure path -> ERROR.
- WARM: count to WARM_CYCLES-1, then go to FETCH.
- FETCH: one clock; registers the ROM entry for cur_step. ROM output is combinational from cur_step.
- ISSUE: cmd_valid=1 with fields driven from the registered entry, stable while cmd_valid is high. On cmd_valid && cmd_ready, drop cmd_valid the next clock and go to WAIT_RSP.
- WAIT_RSP: on rsp_valid:
  - WRITE -> NEXT.
  - VERIFY -> CHECK.
  - RMW -> capture rdata, compute the write value, go to WB_ISSUE.
- WB_ISSUE and WB_WAIT behave like ISSUE and WAIT_RSP, with cmd_wr=1; then go to NEXT.
- CHECK: on pass -> NEXT; on mismatch -> failure.
- Timeout: the counter clears on entry to ISSUE, WAIT_RSP, WB_ISSUE and WB_WAIT. Reaching TIMEOUT_CYCLES counts as a failure.
- Failure handling:
  - If retry < MAX_RETRY: retry++ and go to FETCH, re-running the whole step including the RMW read.
  - Otherwise: go to ERROR; init_error=1, err_step=cur_step, cmd_valid=0.
- NEXT: retry=0. If cur_step == NUM_STEPS-1 go to DONE and set init_done=1 the next clock; otherwise cur_step++.
- DONE and ERROR are terminal; only restart or reset exits them.
- restart handling:
  - In any state: clear init_done, init_error, err_step, retry and cur_step, deassert cmd_valid, go to FETCH.
  - If a command is outstanding, the late rsp_valid is ignored, because FETCH does not sample it.
  - restart during WARM is ignored.
- rsp_valid arriving in any state other than WAIT_RSP or WB_WAIT is ignored.
- Simultaneous rsp_valid and timeout expiry in the same clock: rsp_valid wins.
- init_done and init_error are never high together.

Decomposition:
- Shared package ksz_init_pkg holds:
  - op encodings OP_WRITE/OP_VERIFY/OP_RMW/OP_DELAY;
  - the entry struct/width constants;
  - register offset constants: CIDER 0xC0, MARL 0x10, MARM 0x12, MARH 0x14, TXFDPR 0x84, TXCR 0x70, RXFDPR 0x86, RXFCTR 0x9C, RXCR1 0x74, RXCR2 0x76, RXQCR 0x82, P1CR 0xF6, ISR 0x92, IER 0x90.
- Sub-module ksz_init_rom: combinational step-to-entry lookup. This lets the table change without touching the FSM.
- Default table:
  - VERIFY CIDER a=0x8870, b=0xFFF0.
  - Writes: MAC 0x89AB/0x4567/0x0123, 0x4000, 0x01EE, 0x4000, 0x0001, 0x74F2, 0x0016, 0x0030.
  - RMW P1CR a=0x2000, b=0x0020.
  - Writes: ISR 0xFFFF, IER 0x6000.
  - RMW TXCR a=0x0001, b=0.
  - RMW RXCR1 a=0x0001, b=0.

Test Plan:
1. WARM_CYCLES=8, responder with 1-clock ready and 2-clock rsp -> all steps complete; init_done=1; write of 0x89AB to 0x10 observed; no init_error.
2. CIDER returns 0x8872 -> verify passes (masked), sequence proceeds.
3. CIDER returns 0x1234 on every read -> 4 reads of 0xC0 (1 + MAX_RETRY), then init_error=1, err_step=0, cmd_valid stays 0.
4. P1CR read returns 0x00FF -> write to 0xF6 with data 0x20DF; TXCR read 0x0000 -> write 0x0001.
5. Responder withholds rsp_valid for 1024 clocks at step 5, then behaves -> same command reissued once; completes with init_done=1.
6. restart pulsed while WAIT_RSP at step 7, then stale rsp_valid -> sequence restarts at step 0 with no warm-up; stale pulse ignored; init_done=1 at end.
